imem_loader: RTL and testbench

- Boot-time writer for the byte-addressed, little-endian instruction memory that the fetch path reads (4 KB default window; the memory array is 8192 bytes).
- Accepts a byte stream through a valid/ready handshake: a 4-byte little-endian length header, then the payload bytes.
- Drives one byte-wide write per accepted payload byte into the memory's write port.
- Holds the core in reset (core_hold) until the image is fully written.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_le_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared types and defaults for the instruction-memory boot loader.
// Revision : 1.0
// ============================================================================
package imem_loader_pkg;

    localparam int HDR_BYTES     = 4;
    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_MAX_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LEN       = 3'd1,
        DATA      = 3'd2,
        CSUM      = 3'd3,
        DONE_WAIT = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream input and byte-wide memory write port of the loader.
// Revision : 1.0
// ============================================================================
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_le_assembler.sv
`default_nettype none
// ============================================================================
// Module   : imem_le_assembler
// Brief    : Shifts in 4 bytes little-endian into a 32-bit word; holds when full.
// Revision : 1.0
// ============================================================================
module imem_le_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_shift_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [31:0] o_word_next,
    output logic        o_last
);
    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic        r_full;
    logic        w_shift;

    assign w_shift     = i_shift_en && !r_full;
    // Newest byte enters at the top so the first byte ends up in bits 7:0.
    assign o_word_next = {i_byte, r_word[31:8]};
    assign o_last      = w_shift && (r_cnt == 2'(HDR_BYTES - 1));
    assign o_word      = r_word;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word <= 32'd0;
            r_cnt  <= 2'd0;
            r_full <= 1'b0;
        end else if (w_shift) begin
            r_word <= o_word_next;
            r_cnt  <= r_cnt + 2'd1;
            if (o_last) begin
                r_full <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time byte-stream writer for instruction memory; holds the core
//            until the image is written. IMEM_LOADER_CHECKSUM_EN adds a trailing
//            mod-256 checksum byte.
// Revision : 1.0
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_hold,
    output logic          done,
    output logic          error
);
    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t c_after_data = CSUM;
`else
    localparam state_t c_after_data = DONE_WAIT;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_restart;
    logic              w_data_acc;
    logic              w_data_last;
    logic              w_hdr_last;
    logic [31:0]       w_len;
    logic [31:0]       w_len_next;
    logic [31:0]       r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_data_acc  = w_accept && (r_state == DATA);
    assign w_restart   = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_data_last = (r_count == (w_len - 32'd1));

    imem_le_assembler u_len (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (w_restart),
        .i_shift_en  (w_accept && (r_state == LEN)),
        .i_byte      (bus.in_data),
        .o_word      (w_len),
        .o_word_next (w_len_next),
        .o_last      (w_hdr_last)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_csum <= 8'd0;
        end else if (w_data_acc) begin
            r_csum <= r_csum + bus.in_data;
        end
    end
`endif

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LEN;
            end
            LEN: begin
                w_in_ready = 1'b1;
                // Decide on the header value including the byte being accepted now.
                if (w_accept && w_hdr_last) begin
                    if (w_len_next == 32'd0)
                        w_next = DONE_WAIT;
                    else if ((w_len_next > 32'(MAX_BYTES)) || (w_len_next[1:0] != 2'b00))
                        w_next = ERR;
                    else
                        w_next = DATA;
                end
            end
            DATA: begin
                w_in_ready = 1'b1;
                if (w_accept && w_data_last) w_next = c_after_data;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                w_in_ready = 1'b1;
                if (w_accept) w_next = (bus.in_data == r_csum) ? DONE_WAIT : ERR;
            end
`endif
            DONE_WAIT: w_next = DONE;
            DONE, ERR: begin
                if (start) w_next = LEN;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= 32'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
        end else begin
            r_state <= w_next;
            r_wr_en <= 1'b0;
            if (w_restart) begin
                r_count <= 32'd0;
            end else if (w_data_acc) begin
                r_count   <= r_count + 32'd1;
                r_wr_en   <= 1'b1;
                r_wr_addr <= c_base + r_count[ADDR_W-1:0];
                r_wr_data <= bus.in_data;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign done         = (r_state == DONE);
    assign error        = (r_state == ERR);
    assign core_hold    = (r_state != DONE);
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader; checksum steps are
//            built only with IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic core_hold, done, error;
    int   total = 0;
    int   bad = 0;
    int   wcnt = 0;
    int   w0;
    logic [7:0] mem [0:8191];

    imem_loader_if #(.ADDR_W(13)) bus ();

    imem_loader #(.ADDR_W(13), .BASE_ADDR(0), .MAX_BYTES(4096)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) begin
            mem[bus.wr_addr] <= bus.wr_data;
            wcnt <= wcnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $error("FAIL ready_timeout: observed=in_ready low expected=in_ready high");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] len);
        send(len[7:0]);
        send(len[15:8]);
        send(len[23:16]);
        send(len[31:24]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk1("rst_core_hold", core_hold, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);

        // 8-byte image
        pulse_start();
        chk1("len_ready", bus.in_ready, 1'b1);
        send_hdr(32'd8);
        send(8'h93);
        chk1("first_wr_en", bus.wr_en, 1'b1);
        chk("first_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("first_wr_data", 32'(bus.wr_data), 32'h93);
        send(8'h00); send(8'h20); send(8'h00);
        send(8'h13); send(8'h01); send(8'h30); send(8'h00);
        chk1("last_wr_en", bus.wr_en, 1'b1);
        chk("last_wr_addr", 32'(bus.wr_addr), 32'd7);
        chk1("dw_done", done, 1'b0);
        chk1("dw_hold", core_hold, 1'b1);
        tick();
        chk1("img8_done", done, 1'b1);
        chk1("img8_hold", core_hold, 1'b0);
        chk1("img8_wr_en_off", bus.wr_en, 1'b0);
        chk1("img8_ready_off", bus.in_ready, 1'b0);
        chk("img8_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h00200093);
        chk("img8_word1", {mem[7], mem[6], mem[5], mem[4]}, 32'h00300113);
        chk("img8_wcnt", 32'(wcnt), 32'd8);

        // Length not a multiple of 4
        pulse_start();
        chk1("restart_done_clr", done, 1'b0);
        chk1("restart_hold", core_hold, 1'b1);
        send_hdr(32'd6);
        chk1("len6_error", error, 1'b1);
        chk1("len6_hold", core_hold, 1'b1);
        chk1("len6_ready", bus.in_ready, 1'b0);
        chk1("len6_wr_en", bus.wr_en, 1'b0);
        tick();
        chk("len6_wcnt", 32'(wcnt), 32'd8);
        pulse_start();
        chk1("err_restart_clr", error, 1'b0);
        send_hdr(32'd4);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        tick();
        chk1("recover_done", done, 1'b1);
        chk1("recover_error", error, 1'b0);
        chk("recover_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'hDDCCBBAA);

        // Length above MAX_BYTES
        pulse_start();
        send_hdr(32'h0000_1004);
        chk1("over_max_error", error, 1'b1);

        // Exactly MAX_BYTES, back-to-back
        pulse_start();
        w0 = wcnt;
        send_hdr(32'd4096);
        for (int i = 0; i < 4096; i++) send(8'(i));
        chk("max_last_addr", 32'(bus.wr_addr), 32'd4095);
        tick();
        chk1("max_done", done, 1'b1);
        chk("max_wcnt", 32'(wcnt - w0), 32'd4096);
        chk("max_mem4095", 32'(mem[4095]), 32'hFF);
        chk("max_mem256", 32'(mem[256]), 32'h00);

        // Zero length
        pulse_start();
        w0 = wcnt;
        send_hdr(32'd0);
        chk1("zero_dw_done", done, 1'b0);
        chk1("zero_dw_wr_en", bus.wr_en, 1'b0);
        tick();
        chk1("zero_done", done, 1'b1);
        chk("zero_wcnt", 32'(wcnt - w0), 32'd0);

        // Stalled payload: in_valid 1,0,0,1
        pulse_start();
        w0 = wcnt;
        send_hdr(32'd4);
        send(8'h11);
        chk1("stall_wr0", bus.wr_en, 1'b1);
        chk("stall_addr0", 32'(bus.wr_addr), 32'd0);
        tick();
        chk1("stall_gap1", bus.wr_en, 1'b0);
        tick();
        chk1("stall_gap2", bus.wr_en, 1'b0);
        send(8'h22);
        chk("stall_addr1", 32'(bus.wr_addr), 32'd1);
        send(8'h33); send(8'h44);
        chk("stall_addr3", 32'(bus.wr_addr), 32'd3);
        tick();
        chk1("stall_done", done, 1'b1);
        chk("stall_wcnt", 32'(wcnt - w0), 32'd4);
        chk("stall_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h44332211);

        // Reset mid-load after 2 payload bytes
        pulse_start();
        send_hdr(32'd4);
        send(8'h55);
        send(8'h66);
        reset = 1'b1;
        tick();
        chk1("mid_rst_wr_en", bus.wr_en, 1'b0);
        chk("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk1("mid_rst_ready", bus.in_ready, 1'b0);
        chk1("mid_rst_hold", core_hold, 1'b1);
        chk1("mid_rst_done", done, 1'b0);
        chk1("mid_rst_error", error, 1'b0);
        chk("mid_rst_mem0", 32'(mem[0]), 32'h55);
        chk("mid_rst_mem1", 32'(mem[1]), 32'h66);
        chk("mid_rst_mem2", 32'(mem[2]), 32'h33);
        reset = 1'b0;
        tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send_hdr(32'd4);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk1("csum_wait_ready", bus.in_ready, 1'b1);
        chk1("csum_wait_done", done, 1'b0);
        send(8'h0A);
        tick();
        chk1("csum_ok_done", done, 1'b1);
        pulse_start();
        send_hdr(32'd4);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0B);
        chk1("csum_bad_error", error, 1'b1);
        chk1("csum_bad_hold", core_hold, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
